// File: rtl/leak_keystream_decoder.sv
// Receive side of the LFSR-masked key-leak channel: unmasks leak words with a regenerated
// 16-bit keystream and locks onto a key once enough consecutive decoded words agree.
module leak_keystream_decoder #(
  parameter int unsigned WIDTH   = 64,
  parameter logic [15:0] SEED    = 16'hDEAD,
  parameter logic [15:0] TAPS    = 16'hB400,
  parameter int unsigned CONFIRM = 4,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] leak_in,
  input  logic             leak_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] plain_out,
  output logic             plain_valid,
  output logic [WIDTH-1:0] key_out,
  output logic             key_valid,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned REP = WIDTH / 16;
  localparam int unsigned MW  = $clog2(CONFIRM + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WIDTH-1:0] plain_q, plain_d;
  logic             pvalid_q, pvalid_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             kvalid_q, kvalid_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic [15:0]      lfsr_use_c;
  logic [15:0]      lfsr_step_c;
  logic [WIDTH-1:0] dec_c;

  // A sync word always decodes against SEED, otherwise against the running LFSR.
  assign lfsr_use_c  = sync ? SEED : lfsr_q;
  assign lfsr_step_c = {lfsr_use_c[14:0], ^(lfsr_use_c & TAPS)};
  assign dec_c       = leak_in ^ {REP{lfsr_use_c}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED;
      cand_q   <= '0;
      match_q  <= '0;
      plain_q  <= '0;
      pvalid_q <= 1'b0;
      key_q    <= '0;
      kvalid_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      plain_q  <= plain_d;
      pvalid_q <= pvalid_d;
      key_q    <= key_d;
      kvalid_q <= kvalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cand_d   = cand_q;
    match_d  = match_q;
    plain_d  = plain_q;
    pvalid_d = 1'b0;
    key_d    = key_q;
    kvalid_d = kvalid_q;
    err_d    = err_q;

    if (leak_valid) begin
      plain_d  = dec_c;
      pvalid_d = 1'b1;
      if (sync) begin
        // Sync restarts acquisition from any state without counting as a lock loss.
        lfsr_d   = lfsr_step_c;
        cand_d   = dec_c;
        match_d  = '0;
        kvalid_d = 1'b0;
        state_d  = ACQUIRE;
      end else begin
        unique case (state_q)
          IDLE: ;
          ACQUIRE: begin
            lfsr_d = lfsr_step_c;
            if (dec_c == cand_q) begin
              if (match_q == MW'(CONFIRM - 1)) begin
                key_d    = dec_c;
                kvalid_d = 1'b1;
                match_d  = '0;
                state_d  = LOCKED;
              end else begin
                match_d = match_q + MW'(1);
              end
            end else begin
              cand_d  = dec_c;
              match_d = '0;
            end
          end
          LOCKED: begin
            lfsr_d = lfsr_step_c;
            if (dec_c != key_q) begin
              kvalid_d = 1'b0;
              if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
              cand_d   = dec_c;
              match_d  = '0;
              state_d  = ACQUIRE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign plain_out   = plain_q;
  assign plain_valid = pvalid_q;
  assign key_out     = key_q;
  assign key_valid   = kvalid_q;
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_leak_keystream_decoder.sv
// Scoreboard bench for leak_keystream_decoder: a transmitter model masks chosen plain words,
// a monitor compares every plain_valid pulse against the queued expectation.
module tb_leak_keystream_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] leak_in;
  logic        leak_valid;
  logic        sync;

  logic [63:0] plain_out, key_out;
  logic        plain_valid, key_valid;
  logic [7:0]  err_cnt;
  logic [63:0] plain2, key2;
  logic        pvalid2, kvalid2;
  logic [1:0]  err2;

  leak_keystream_decoder dut (
    .clk(clk), .rst_n(rst_n), .leak_in(leak_in), .leak_valid(leak_valid), .sync(sync),
    .plain_out(plain_out), .plain_valid(plain_valid), .key_out(key_out),
    .key_valid(key_valid), .err_cnt(err_cnt)
  );

  leak_keystream_decoder #(.ERR_W(2)) dut_e2 (
    .clk(clk), .rst_n(rst_n), .leak_in(leak_in), .leak_valid(leak_valid), .sync(sync),
    .plain_out(plain2), .plain_valid(pvalid2), .key_out(key2),
    .key_valid(kvalid2), .err_cnt(err2)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] expq[$];
  logic [15:0] tx_l;

  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'hFFFF0000FFFF0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  // Monitor: pops the scoreboard on each plain_valid pulse.
  always @(negedge clk) begin
    if (plain_valid) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL plain_unexpected: got %h expected no output", plain_out);
      end else begin
        logic [63:0] e;
        e = expq.pop_front();
        check("plain_out", plain_out, e);
        check("plain_out_e2", plain2, e);
        check("plain_valid_e2", {63'd0, pvalid2}, 64'd1);
      end
    end
  end

  // Drive one accepted word at a negedge; returns at the negedge after acceptance.
  task automatic send_raw(input logic [63:0] leak, input logic s, input logic [63:0] exp);
    leak_in    = leak;
    sync       = s;
    leak_valid = 1'b1;
    expq.push_back(exp);
    @(negedge clk);
    leak_valid = 1'b0;
    sync       = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] key, input logic s, input logic [63:0] flip);
    logic [15:0] l;
    l = s ? 16'hDEAD : tx_l;
    send_raw(key ^ {4{l}} ^ flip, s, key ^ flip);
    tx_l = step16(l);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      check("gap_valid", {63'd0, plain_valid}, 64'd0);
    end
  endtask

  // Sync word plus CONFIRM matching words; key_valid must rise exactly on the fifth.
  task automatic lock_seq(input logic [63:0] key, input int g, input logic [7:0] err_exp);
    send_key(key, 1'b1, 64'd0);
    check("sync_drops_kv", {63'd0, key_valid}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (g > 0) gap(g);
      send_key(key, 1'b0, 64'd0);
      check("kv_during_acq", {63'd0, key_valid}, (i == 3) ? 64'd1 : 64'd0);
    end
    check("key_out", key_out, key);
    check("err_cnt", {56'd0, err_cnt}, {56'd0, err_exp});
  endtask

  initial begin
    rst_n      = 1'b0;
    leak_valid = 1'b0;
    sync       = 1'b0;
    leak_in    = '0;
    tx_l       = 16'hDEAD;
    repeat (2) @(negedge clk);
    check("rst_plain_out", plain_out, 64'd0);
    check("rst_plain_valid", {63'd0, plain_valid}, 64'd0);
    check("rst_key_out", key_out, 64'd0);
    check("rst_key_valid", {63'd0, key_valid}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First non-sync word after sync is masked with step(DEAD) = BD5B.
    leak_in = '0;
    send_raw(K1 ^ {4{16'hDEAD}}, 1'b1, K1);
    tx_l = 16'hBD5B;
    send_raw(K1 ^ {4{16'hBD5B}}, 1'b0, K1);
    tx_l = step16(16'hBD5B);
    for (int i = 0; i < 3; i++) begin
      send_key(K1, 1'b0, 64'd0);
      check("t1_kv", {63'd0, key_valid}, (i == 2) ? 64'd1 : 64'd0);
    end
    check("t1_key_out", key_out, K1);
    check("t1_err", {56'd0, err_cnt}, 64'd0);

    // Stalled stream, re-sync while locked.
    lock_seq(K1, 3, 8'd0);

    // Single corrupted word breaks lock; five good words to relock.
    send_key(K1, 1'b0, 64'd1);
    check("t3_kv", {63'd0, key_valid}, 64'd0);
    check("t3_err", {56'd0, err_cnt}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      send_key(K1, 1'b0, 64'd0);
      check("t3_relock", {63'd0, key_valid}, (i == 4) ? 64'd1 : 64'd0);
    end
    check("t3_key_out", key_out, K1);

    // Sync to a new key while locked does not count as an error.
    lock_seq(K2, 0, 8'd1);

    // Reset mid-acquire.
    send_key(K1, 1'b1, 64'd0);
    send_key(K1, 1'b0, 64'd0);
    send_key(K1, 1'b0, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_plain_out", plain_out, 64'd0);
    check("t5_plain_valid", {63'd0, plain_valid}, 64'd0);
    check("t5_key_out", key_out, 64'd0);
    check("t5_key_valid", {63'd0, key_valid}, 64'd0);
    check("t5_err", {56'd0, err_cnt}, 64'd0);
    // Without a sync the decoder stays idle, decoding against SEED.
    for (int i = 0; i < 6; i++) begin
      logic [63:0] lk;
      lk = K1 ^ {4{tx_l}};
      send_raw(lk, 1'b0, lk ^ {4{16'hDEAD}});
      tx_l = step16(tx_l);
      check("t5_no_lock", {63'd0, key_valid}, 64'd0);
    end
    lock_seq(K1, 0, 8'd0);

    // Repeated lock losses; the 2-bit counter saturates at 3.
    for (int i = 1; i <= 5; i++) begin
      send_key(K1, 1'b0, 64'h8000_0000_0000_0000);
      check("t6_kv", {63'd0, key_valid}, 64'd0);
      check("t6_err8", {56'd0, err_cnt}, 64'(i));
      check("t6_err2", {62'd0, err2}, (i > 3) ? 64'd3 : 64'(i));
      for (int j = 0; j < 5; j++) send_key(K1, 1'b0, 64'd0);
      check("t6_relock", {63'd0, key_valid}, 64'd1);
      check("t6_relock_e2", {63'd0, kvalid2}, 64'd1);
    end

    @(negedge clk);
    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
